conv_encoder_top: RTL and testbench

//  Rate-1/2, K=3 convolutional encoder (G0=7, G1=5 octal): the transmit end of the Viterbi link.

---
 rtl/viterbi_pkg.sv | 23 ++
 rtl/conv_enc_unit.sv | 32 +++
 rtl/conv_encoder_top.sv | 120 ++++++++++++
 tb/tb_conv_encoder_top.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Constants shared by the convolutional encoder and the Viterbi decoder so the two
// ends of the link cannot drift apart: code polynomials, symbol order, widths.
package viterbi_pkg;

    localparam int unsigned K      = 3;
    localparam int unsigned MemW   = K - 1;
    localparam logic [K-1:0] G0    = 3'b111;  // symbol bit [1]
    localparam logic [K-1:0] G1    = 3'b101;  // symbol bit [0]
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CODE_W = 2 * DATA_W;
    localparam int unsigned CNT_W  = $clog2(DATA_W);

    typedef enum logic {
        StIdle,
        StEnc
    } enc_state_e;

    // taps are ordered {current bit, m1, m2}; result is {g0, g1}
    function automatic logic [1:0] conv_sym(input logic [K-1:0] taps);
        return {^(G0 & taps), ^(G1 & taps)};
    endfunction

endpackage

// File: rtl/conv_enc_unit.sv
// Single-bit K=3 convolutional encoder core: combinational symbol output from the
// current bit and the stored memory; memory advances only when en_i is set.
module conv_enc_unit
    import viterbi_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       bit_i,
    input  logic       en_i,
    output logic [1:0] sym_o
);

    logic [MemW-1:0] mem_q, mem_d;

    assign sym_o = conv_sym({bit_i, mem_q});

    always_comb begin
        mem_d = mem_q;
        if (en_i) begin
            mem_d = {bit_i, mem_q[MemW-1:1]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/conv_encoder_top.sv
// Byte-oriented rate-1/2 encoder: one-entry hold register feeding a bit-serial engine
// that packs eight symbols, MSB first, into one 16-bit code word per byte.
module conv_encoder_top
    import viterbi_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dvalid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [CODE_W-1:0] data_o,
    output logic              valid_o,
    output logic              busy_o
);

    localparam logic [CNT_W-1:0] LastBit = CNT_W'(DATA_W - 1);

    enc_state_e        state_q, state_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_v_q, hold_v_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [CODE_W-3:0] pack_q, pack_d;
    logic [CODE_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;

    logic       accept;
    logic       drain;
    logic       enc_en;
    logic [1:0] sym;

    conv_enc_unit u_enc (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bit_i  (shreg_q[DATA_W-1]),
        .en_i   (enc_en),
        .sym_o  (sym)
    );

    // A fill needs an empty hold and a drain needs a full one, so they never collide.
    assign accept = dvalid_i && !hold_v_q;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        pack_d    = pack_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        drain     = 1'b0;
        enc_en    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (hold_v_q) begin
                    shreg_d   = hold_q;
                    drain     = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = StEnc;
                end
            end
            StEnc: begin
                enc_en    = 1'b1;
                pack_d    = {pack_q[CODE_W-5:0], sym};
                shreg_d   = {shreg_q[DATA_W-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (bit_cnt_q == LastBit) begin
                    data_d    = {pack_q, sym};
                    valid_d   = 1'b1;
                    bit_cnt_d = '0;
                    if (hold_v_q) begin
                        // back-to-back reload keeps the engine bubble-free
                        shreg_d = hold_q;
                        drain   = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        hold_d   = hold_q;
        hold_v_d = hold_v_q;
        if (accept) begin
            hold_d   = data_i;
            hold_v_d = 1'b1;
        end else if (drain) begin
            hold_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            hold_q    <= '0;
            hold_v_q  <= 1'b0;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            pack_q    <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            hold_v_q  <= hold_v_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            pack_q    <= pack_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign busy_o  = hold_v_q;

endmodule

// File: tb/tb_conv_encoder_top.sv
// Bench for conv_encoder_top: directed cases plus a random byte stream, all checked
// against an arithmetic reference encoder with its own memory carried across bytes.
module tb_conv_encoder_top;

    logic        clk;
    logic        rst_n;
    logic        dvalid_i;
    logic [7:0]  data_i;
    logic [15:0] data_o;
    logic        valid_o;
    logic        busy_o;

    conv_encoder_top dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .dvalid_i (dvalid_i),
        .data_i   (data_i),
        .data_o   (data_o),
        .valid_o  (valid_o),
        .busy_o   (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp;
    int          n_err;
    int          n_acc;
    int          n_extra;
    int          cyc;
    int          ref_mem;
    logic [15:0] last_word;
    logic [15:0] exp_q[$];
    int          vcyc_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: memory as an integer {m1,m2}; symbol = {b^m1^m2, b^m2}.
    function automatic logic [15:0] ref_encode(input logic [7:0] b, inout int mem);
        int word;
        int bv, m1, m2;
        word = 0;
        for (int i = 7; i >= 0; i--) begin
            bv   = (b >> i) & 1;
            m1   = (mem >> 1) & 1;
            m2   = mem & 1;
            word = word * 4 + ((bv + m1 + m2) % 2) * 2 + ((bv + m2) % 2);
            mem  = bv * 2 + m1;
        end
        return word[15:0];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: outputs and acceptance are sampled mid-cycle, away from the edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid_o) begin
                vcyc_q.push_back(cyc);
                last_word = data_o;
                if (exp_q.size() > 0) check_val("word", data_o, exp_q.pop_front());
                else n_extra++;
            end
            if (dvalid_i && !busy_o) begin
                exp_q.push_back(ref_encode(data_i, ref_mem));
                n_acc++;
            end
        end
    end

    task automatic do_reset();
        dvalid_i = 1'b0;
        data_i   = 8'h00;
        rst_n    = 1'b0;
        exp_q.delete();
        ref_mem = 0;
        #1;
        check_val("rst_data", data_o, 16'h0000);
        check_val("rst_valid", valid_o, 1'b0);
        check_val("rst_busy", busy_o, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        dvalid_i = 1'b1;
        data_i   = b;
        @(posedge clk);
        #1 dvalid_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && exp_q.size() > 0; i++) @(posedge clk);
        check_val("drain_left", exp_q.size(), 0);
        repeat (3) @(posedge clk);
    endtask

    initial begin
        int e;
        int acc0;
        int seen_busy;
        n_cmp = 0; n_err = 0; n_acc = 0; n_extra = 0; cyc = 0; ref_mem = 0;
        last_word = '0;

        // 1: zero byte, latency from acceptance edge to valid_o
        do_reset();
        @(posedge clk);
        #1;
        dvalid_i = 1'b1;
        data_i   = 8'h00;
        @(posedge clk);
        #1 dvalid_i = 1'b0;
        e = 0;
        for (int i = 0; i < 20; i++) begin
            if (valid_o) break;
            @(posedge clk);
            e++;
            #1;
        end
        check_val("t1_latency", e, 9);
        drain();
        check_val("t1_word", last_word, 16'h0000);

        // 2: single 0x80
        do_reset();
        send_byte(8'h80);
        drain();
        check_val("t2_word", last_word, 16'hEC00);

        // 3: memory carried across bytes
        do_reset();
        send_byte(8'hFF);
        drain();
        check_val("t3_word0", last_word, 16'hDAAA);
        send_byte(8'h00);
        drain();
        check_val("t3_word1", last_word, 16'h7000);

        // 4: dvalid held high for 20 edges; only non-busy writes are taken
        do_reset();
        acc0 = n_acc;
        vcyc_q.delete();
        seen_busy = 0;
        @(posedge clk);
        #1;
        dvalid_i = 1'b1;
        data_i   = 8'h80;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (busy_o) seen_busy = 1;
        end
        dvalid_i = 1'b0;
        drain();
        check_val("t4_busy_seen", seen_busy, 1);
        check_val("t4_accepted", n_acc - acc0, 4);
        check_val("t4_words", vcyc_q.size(), 4);
        for (int i = 1; i < vcyc_q.size(); i++) check_val("t4_gap", vcyc_q[i] - vcyc_q[i-1], 8);
        check_val("t4_word", last_word, 16'hEC00);

        // 5: reset in the middle of encoding
        do_reset();
        send_byte(8'hFF);
        drain();
        send_byte(8'h5A);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        ref_mem = 0;
        #1;
        check_val("t5_data", data_o, 16'h0000);
        check_val("t5_valid", valid_o, 1'b0);
        check_val("t5_busy", busy_o, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        send_byte(8'h80);
        drain();
        check_val("t5_word", last_word, 16'hEC00);

        // 6: random 64-byte stream with random gaps and writes while busy
        do_reset();
        acc0 = n_acc;
        for (int i = 0; i < 6000 && (n_acc - acc0) < 64; i++) begin
            @(posedge clk);
            #1;
            dvalid_i = ($urandom_range(0, 3) != 0);
            data_i   = 8'($urandom);
        end
        #1 dvalid_i = 1'b0;
        check_val("t6_accepted", n_acc - acc0, 64);
        drain();

        check_val("extra_words", n_extra, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
